paralelo_serial_tx: RTL and testbench

Transmit-side parallel-to-serial stage of the PHY lane. It accepts 8-bit payload words from the link layer through a valid/ready handshake into a small FIFO. It serializes them MSB-first at clk_32f, one bit per cycle and 8 cycles per word. It inserts comma (0xBC) training and idle words so the downstream serial_paralelo receiver can lock, and so that receiver flags gaps as invalid.

---
 rtl/paralelo_serial_tx_if.sv | 28 ++
 rtl/paralelo_serial_tx.sv | 91 +++++++++
 tb/tb_paralelo_serial_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_if.sv
// Link-layer side of the PHY transmit lane: the valid/ready payload path
// and the serial stream with its framing flags.
interface paralelo_serial_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       word_strobe;
    logic       active_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  word_strobe,
        input  active_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output word_strobe,
        output active_out
    );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: buffers payload words in a small FIFO and
// shifts them out MSB-first, filling training and idle slots with commas.
module paralelo_serial_tx #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         TRAIN_WORDS = 4,
    parameter int         FIFO_DEPTH  = 4
) (
    input logic                 clk_32f,
    input logic                 reset,
    paralelo_serial_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] TRAIN  = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]    state;
    logic [2:0]    bit_cnt;
    logic [3:0]    train_cnt;
    logic [6:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          load;
    logic          push;
    logic          pop;
    logic          last_train;
    logic [7:0]    word;

    // Comma payload is accepted on the handshake but dropped so it never aliases idle fill.
    always_comb begin
        load       = (bit_cnt == 3'd7);
        push       = bus.valid_in && bus.ready_out && (bus.data_in != COMMA);
        pop        = load && (state == ACTIVE) && (count != '0);
        last_train = (state == TRAIN) && (train_cnt == 4'(TRAIN_WORDS - 1));
        word       = pop ? mem[rd_ptr] : COMMA;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state           <= TRAIN;
            bit_cnt         <= 3'd7;
            train_cnt       <= '0;
            shreg           <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            bus.ready_out   <= 1'b0;
            bus.data_out    <= 1'b0;
            bus.word_strobe <= 1'b0;
            bus.active_out  <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                // shreg keeps only bits 6..0; bit 7 goes straight to the line.
                shreg           <= word[6:0];
                bus.data_out    <= word[7];
                bus.word_strobe <= 1'b1;
                if (state == TRAIN) begin
                    train_cnt <= train_cnt + 4'd1;
                    if (last_train) begin
                        state          <= ACTIVE;
                        bus.active_out <= 1'b1;
                    end
                end
            end else begin
                shreg           <= {shreg[5:0], 1'b0};
                bus.data_out    <= shreg[6];
                bus.word_strobe <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count         <= count_next;
            bus.ready_out <= (count_next < CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset && push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench: directed phases with random payload, compared each
// cycle against a slot-level model of the serial stream.
module tb_paralelo_serial_tx;
    localparam logic [7:0] COMMA       = 8'hBC;
    localparam int         TRAIN_WORDS = 4;
    localparam int         FIFO_DEPTH  = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    paralelo_serial_tx_if bus ();

    paralelo_serial_tx #(
        .COMMA       (COMMA),
        .TRAIN_WORDS (TRAIN_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int         checks = 0;
    int         errors = 0;
    int         t = -1;
    logic [7:0] fifo_q[$];
    logic [7:0] cur_word = 8'h00;
    logic       m_ready = 1'b0;
    logic       exp_data = 1'b0;
    logic       exp_strobe = 1'b0;
    logic       exp_active = 1'b0;

    // Slot model: every 8th edge after release starts a word; the first
    // TRAIN_WORDS slots are commas, later slots take the FIFO head or idle.
    task automatic modelEdge();
        logic accepted;
        if (!reset) begin
            fifo_q.delete();
            t          = -1;
            cur_word   = 8'h00;
            m_ready    = 1'b0;
            exp_data   = 1'b0;
            exp_strobe = 1'b0;
            exp_active = 1'b0;
        end else begin
            t = t + 1;
            accepted = bus.valid_in && m_ready;
            if (t % 8 == 0) begin
                if (t / 8 < TRAIN_WORDS)   cur_word = COMMA;
                else if (fifo_q.size() > 0) cur_word = fifo_q.pop_front();
                else                        cur_word = COMMA;
            end
            if (accepted && bus.data_in != COMMA) fifo_q.push_back(bus.data_in);
            m_ready    = (fifo_q.size() < FIFO_DEPTH);
            exp_data   = cur_word[7 - (t % 8)];
            exp_strobe = (t % 8 == 0);
            exp_active = (t >= 8 * (TRAIN_WORDS - 1));
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s t=%0d: observed %b expected %b", tag, t, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkBit("data_out", bus.data_out, exp_data);
        checkBit("word_strobe", bus.word_strobe, exp_strobe);
        checkBit("active_out", bus.active_out, exp_active);
        checkBit("ready_out", bus.ready_out, m_ready);
    endtask

    task automatic applyStimulus(input logic rst_n, input logic v, input logic [7:0] d);
        reset        = rst_n;
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk_32f);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] randPayload();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        if (w == COMMA) w = 8'h5A;
        return w;
    endfunction

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        $display("[TB] reset and idle training stream");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        idle(48);

        $display("[TB] payload pushed during training");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        idle(5);
        applyStimulus(1'b1, 1'b1, 8'h3C);
        applyStimulus(1'b1, 1'b1, 8'hA5);
        idle(64);

        $display("[TB] back-to-back burst into a small FIFO");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, randPayload());
        idle(48);
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b1, randPayload());
        idle(48);

        $display("[TB] comma payload is dropped");
        applyStimulus(1'b1, 1'b1, COMMA);
        applyStimulus(1'b1, 1'b1, 8'h01);
        idle(32);

        $display("[TB] push aligned with a load edge");
        for (int i = 0; i < 8 && ((t + 1) % 8) != 0; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, randPayload());
        idle(24);

        $display("[TB] random traffic");
        for (int i = 0; i < 240; i++) begin
            logic       v;
            logic [7:0] d;
            v = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 7) == 0) ? COMMA : 8'($urandom_range(0, 255));
            applyStimulus(1'b1, v, d);
        end
        idle(48);

        $display("[TB] reset mid-word with words queued");
        applyStimulus(1'b1, 1'b1, randPayload());
        applyStimulus(1'b1, 1'b1, randPayload());
        for (int i = 0; i < 8 && (t % 8) != 3; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        idle(64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
